seq_mult_adder: RTL and testbench

Sequential, precision-scalable signed dot-product/accumulate unit. It computes D = C_in + sum over k of row[k]*column[k] on K operand pairs. The operand width is run-time selectable in steps of P bits. The row operand is consumed one P-bit digit per clock, so latency scales with the selected precision. It sits inside a systolic/PE array tile and uses valid/ready handshakes on input and output.

---
 rtl/seq_mult_adder.sv | 124 ++++++++++++
 tb/tb_seq_mult_adder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_mult_adder.sv
// Digit-serial signed dot-product/accumulate (D = C_in + sum row*column). Latency bitSize+1 cycles.
// Holds the result in DONE until ready_out is high, and accepts no input while busy.
module seq_mult_adder #(
  parameter int K         = 2,
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic signed [MAX_WIDTH-1:0]     row    [K],
  input  logic signed [MAX_WIDTH-1:0]     column [K],
  input  logic signed [2*MAX_WIDTH-1:0]   C_in,
  input  logic [$clog2(MAX_WIDTH):0]      bitSize,
  input  logic                            valid_in,
  output logic                            ready_in,
  output logic signed [2*MAX_WIDTH-1:0]   D,
  output logic                            valid_out,
  input  logic                            ready_out
);

  localparam int NDIG = MAX_WIDTH / P;
  localparam int BW   = $clog2(MAX_WIDTH) + 1;
  localparam int IW   = $clog2(MAX_WIDTH);
  localparam int AW   = 2 * MAX_WIDTH;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                 state, state_nxt;
  logic [BW-1:0]          n_eff, n_q, cnt;
  logic signed [AW-1:0]   acc, step_sum;
  logic [MAX_WIDTH-1:0]   row_sh [K];
  logic signed [AW-1:0]   col_sh [K];
  logic                   top_dig;

  // Keep bits [P*nd-1:0] and replicate bit P*nd-1 above them.
  function automatic logic [MAX_WIDTH-1:0] sext(input logic [MAX_WIDTH-1:0] v,
                                                input logic [BW-1:0] nd);
    int                   w;
    logic [IW-1:0]        msb;
    logic [MAX_WIDTH-1:0] r;
    w   = P * int'(nd);
    msb = IW'(w - 1);
    for (int j = 0; j < MAX_WIDTH; j++) begin
      r[j] = (j < w) ? v[j] : v[msb];
    end
    return r;
  endfunction

  always_comb begin
    n_eff = bitSize;
    if (bitSize == '0 || bitSize > BW'(NDIG)) n_eff = BW'(NDIG);
  end

  // Row is consumed low digit first; the column is pre-shifted so each digit
  // product already carries its weight. Only the most significant digit is signed.
  assign top_dig = (cnt == n_q - BW'(1));

  always_comb begin
    step_sum = '0;
    for (int k = 0; k < K; k++) begin
      step_sum = step_sum +
        $signed({{(AW-P){top_dig & row_sh[k][P-1]}}, row_sh[k][P-1:0]}) * col_sh[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in)    state_nxt = COMPUTE;
      COMPUTE: if (cnt == n_q)  state_nxt = DONE;
      DONE:    if (ready_out)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  assign ready_in  = (state == IDLE);
  assign valid_out = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc <= '0;
      cnt <= '0;
      n_q <= '0;
      D   <= '0;
      for (int k = 0; k < K; k++) begin
        row_sh[k] <= '0;
        col_sh[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            acc <= C_in;
            cnt <= '0;
            n_q <= n_eff;
            for (int k = 0; k < K; k++) begin
              row_sh[k] <= sext(row[k], n_eff);
              col_sh[k] <= AW'($signed(sext(column[k], n_eff)));
            end
          end
        end
        COMPUTE: begin
          if (cnt == n_q) begin
            D <= acc;
          end else begin
            acc <= acc + step_sum;
            cnt <= cnt + BW'(1);
            for (int k = 0; k < K; k++) begin
              row_sh[k] <= row_sh[k] >> P;
              col_sh[k] <= col_sh[k] <<< P;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_adder.sv
// Directed bench for seq_mult_adder: hand-computed results, latency, backpressure, reset abort.
module tb_seq_mult_adder;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic signed [15:0] row    [2];
  logic signed [15:0] column [2];
  logic signed [31:0] C_in;
  logic [4:0]         bitSize;
  logic               valid_in;
  logic               ready_in;
  logic signed [31:0] D;
  logic               valid_out;
  logic               ready_out;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  seq_mult_adder #(.K(2), .P(2), .MAX_WIDTH(16)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .row       (row),
    .column    (column),
    .C_in      (C_in),
    .bitSize   (bitSize),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .D         (D),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
             tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // One transaction; inputs are scrambled after acceptance to prove they were latched.
  task automatic run(input string tag, input int bs,
                     input logic [15:0] r0, input logic [15:0] r1,
                     input logic [15:0] c0, input logic [15:0] c1,
                     input logic [31:0] cin, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk_i);
    chk({tag, ".ready_in"}, 32'(ready_in), 32'd1);
    bitSize   = 5'(bs);
    row[0]    = r0;
    row[1]    = r1;
    column[0] = c0;
    column[1] = c1;
    C_in      = cin;
    valid_in  = 1'b1;
    @(posedge clk_i); #1;
    valid_in  = 1'b0;
    row[0]    = 16'h5A5A;
    row[1]    = 16'hA5A5;
    column[0] = 16'h1234;
    column[1] = 16'h8765;
    C_in      = 32'hDEADBEEF;
    bitSize   = 5'd7;
    lat = 0;
    while (!valid_out && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".D"}, D, exp);
    if (ready_out) begin
      @(posedge clk_i); #1;
      chk({tag, ".valid_drop"}, 32'(valid_out), 32'd0);
    end
  endtask

  initial begin
    rst_i     = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    row[0] = '0; row[1] = '0; column[0] = '0; column[1] = '0;
    C_in = '0;
    bitSize = '0;
    repeat (2) @(negedge clk_i);
    chk("reset.D", D, 32'd0);
    chk("reset.valid_out", 32'(valid_out), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset.ready_in", 32'(ready_in), 32'd1);

    run("max16", 8, 16'd32767, 16'd0, 16'd32767, 16'd0, 32'd0, 32'd1073676289, 9);
    run("w2_upper_ignored", 1, 16'hFF03, 16'd0, 16'h0001, 16'd0, 32'd0, 32'hFFFFFFFF, 2);
    run("w4", 2, 16'h0008, 16'd0, 16'h0007, 16'd0, 32'd0, -32'sd56, 3);
    run("w8", 4, 16'h0080, 16'd0, 16'h0080, 16'd0, 32'd0, 32'd16384, 5);
    run("dot_acc", 8, 16'd3, -16'sd4, 16'd5, 16'd6, 32'd100, 32'd91, 9);
    run("bs0_as_max", 0, -16'sd2, 16'd0, -16'sd3, 16'd0, -32'sd10, -32'sd4, 9);
    run("bs_over_max", 15, 16'h8000, 16'd0, 16'h8000, 16'd0, 32'd0, 32'h40000000, 9);
    run("wrap", 8, 16'd1, 16'd0, 16'd1, 16'd0, 32'h7FFFFFFF, 32'h80000000, 9);

    // Backpressure: result must hold while ready_out is low.
    ready_out = 1'b0;
    run("bp", 8, 16'd7, 16'd0, 16'd9, 16'd0, 32'd0, 32'd63, 9);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("bp.valid_hold", 32'(valid_out), 32'd1);
      chk("bp.D_hold", D, 32'd63);
      chk("bp.ready_in_low", 32'(ready_in), 32'd0);
    end
    ready_out = 1'b1;
    @(posedge clk_i); #1;
    chk("bp.valid_drop", 32'(valid_out), 32'd0);
    chk("bp.ready_in_back", 32'(ready_in), 32'd1);
    chk("bp.D_after", D, 32'd63);

    // Reset in the middle of COMPUTE.
    @(negedge clk_i);
    bitSize = 5'd8; row[0] = 16'd100; column[0] = 16'd100; C_in = 32'd0;
    valid_in = 1'b1;
    @(posedge clk_i); #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("abort.D_retained", D, 32'd63);
    chk("abort.busy", 32'(ready_in), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("abort.D", D, 32'd0);
    chk("abort.valid_out", 32'(valid_out), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run("after_abort", 3, 16'd31, 16'd0, 16'hFFE0, 16'd0, 32'd0, -32'sd992, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
